fmul_s2: RTL and testbench



---
 rtl/fmul_s2_pkg.sv | 24 ++
 rtl/fp_lzc8.sv | 20 ++
 rtl/fmul_s2.sv | 174 +++++++++++++++++
 tb/tb_fmul_s2.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmul_s2_pkg.sv
// Shared constants for the FP9 multiplier second stage.
// Holds the FP9 and FP22 format widths, the canonical FP22 quiet NaN
// and the bit positions inside the {NV, DZ, OF, UF, NX} flag vector.
package fmul_s2_pkg;

  // FP9 operand format.
  localparam int unsigned TC_EXPWIDTH       = 5;
  localparam int unsigned TC_PRECISION      = 3;

  // FP22 result format.
  localparam int unsigned TC_FP22_EXPWIDTH  = 8;
  localparam int unsigned TC_FP22_PRECISION = 13;
  localparam int unsigned TC_FP22_BIAS      = 127;
  localparam logic [21:0] TC_FP22_QNAN      = 22'h1FF000;

  // Exception flag bit indices.
  localparam int unsigned TC_FFLAG_W  = 5;
  localparam int unsigned TC_FFLAG_NV = 4;
  localparam int unsigned TC_FFLAG_DZ = 3;
  localparam int unsigned TC_FFLAG_OF = 2;
  localparam int unsigned TC_FFLAG_UF = 1;
  localparam int unsigned TC_FFLAG_NX = 0;

endpackage

// File: rtl/fp_lzc8.sv
// Leading-one position encoder for an 8-bit vector.
// Ports:
//   in_i  - value to scan
//   pos_o - bit index of the most significant set bit (0 when in_i is zero)
module fp_lzc8 (
  input  logic [7:0] in_i,
  output logic [2:0] pos_o
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    pos_o = 3'd0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (in_i[i]) begin
        pos_o = 3'(i);
      end
    end
  end

endmodule

// File: rtl/fmul_s2.sv
// FP9 x FP9 multiplier, second stage: exact significand product,
// normalisation and packing into FP22, behind a two-entry valid/ready pipe.
// Ports:
//   clk_i, rst_i                 - clock, synchronous active-high reset
//   s_valid_i / s_ready_o        - input handshake
//   a_i, b_i                     - raw FP9 operands
//   special_*_i, prod_sign_i     - classification and sign from the first stage
//   rm_i                         - rounding mode, carried through untouched
//   m_valid_o / m_ready_i        - output handshake
//   m_data_o, m_fflags_o, m_rm_o - FP22 product, {NV,DZ,OF,UF,NX}, rounding mode
module fmul_s2
  import fmul_s2_pkg::*;
#(
  parameter int unsigned EXPWIDTH   = TC_EXPWIDTH,
  parameter int unsigned PRECISION  = TC_PRECISION,
  parameter int unsigned OEXPWIDTH  = TC_FP22_EXPWIDTH,
  parameter int unsigned OPRECISION = TC_FP22_PRECISION
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              s_valid_i,
  output logic                              s_ready_o,
  input  logic [EXPWIDTH+PRECISION:0]       a_i,
  input  logic [EXPWIDTH+PRECISION:0]       b_i,
  input  logic                              special_valid_i,
  input  logic                              special_nan_i,
  input  logic                              special_inf_i,
  input  logic                              special_inv_i,
  input  logic                              special_haszero_i,
  input  logic                              prod_sign_i,
  input  logic [2:0]                        rm_i,
  output logic                              m_valid_o,
  input  logic                              m_ready_i,
  output logic [OEXPWIDTH+OPRECISION:0]     m_data_o,
  output logic [TC_FFLAG_W-1:0]             m_fflags_o,
  output logic [2:0]                        m_rm_o
);

  localparam int unsigned MW   = PRECISION + 1;
  localparam int unsigned PW   = 2 * MW;
  localparam int unsigned OW   = 1 + OEXPWIDTH + OPRECISION;
  // Wide enough that ea' + eb' - 2*bias never wraps.
  localparam int unsigned ESW  = 10;
  localparam int unsigned IBIAS = (1 << (EXPWIDTH - 1)) - 1;
  localparam int unsigned OBIAS = TC_FP22_BIAS;

  // ---------------------------------------------------------------------------
  // Stage P1: operand unpack and exact product
  // ---------------------------------------------------------------------------
  logic [EXPWIDTH-1:0]  ea, eb, ea_adj, eb_adj;
  logic [PRECISION-1:0] fa, fb;
  logic [MW-1:0]        ma, mb;
  logic                 snan_a, snan_b;

  always_comb begin
    ea     = a_i[PRECISION +: EXPWIDTH];
    eb     = b_i[PRECISION +: EXPWIDTH];
    fa     = a_i[PRECISION-1:0];
    fb     = b_i[PRECISION-1:0];
    // Subnormals share the minimum normal exponent but lack the hidden one.
    ea_adj = (ea == '0) ? EXPWIDTH'(1) : ea;
    eb_adj = (eb == '0) ? EXPWIDTH'(1) : eb;
    ma     = {(ea != '0), fa};
    mb     = {(eb != '0), fb};
    snan_a = (&ea) && !fa[PRECISION-1] && (fa != '0);
    snan_b = (&eb) && !fb[PRECISION-1] && (fb != '0);
  end

  logic            p1_valid_q;
  logic [PW-1:0]   p1_prod_q;
  logic [ESW-1:0]  p1_esum_q;
  logic            p1_nan_q, p1_inf_q, p1_zero_q, p1_nv_q, p1_sign_q;
  logic [2:0]      p1_rm_q;

  logic            p2_load;
  logic            p1_advance;

  // P2 can take a beat when it is empty or its beat is leaving this cycle.
  assign p2_load    = !m_valid_o || m_ready_i;
  assign p1_advance = p1_valid_q && p2_load;
  assign s_ready_o  = !p1_valid_q || p1_advance;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p1_valid_q <= 1'b0;
      p1_prod_q  <= '0;
      p1_esum_q  <= '0;
      p1_nan_q   <= 1'b0;
      p1_inf_q   <= 1'b0;
      p1_zero_q  <= 1'b0;
      p1_nv_q    <= 1'b0;
      p1_sign_q  <= 1'b0;
      p1_rm_q    <= '0;
    end else if (s_ready_o) begin
      p1_valid_q <= s_valid_i;
      if (s_valid_i) begin
        p1_prod_q <= PW'(ma) * PW'(mb);
        p1_esum_q <= ESW'(ea_adj) + ESW'(eb_adj) - ESW'(2 * IBIAS);
        p1_nan_q  <= special_valid_i && special_nan_i;
        p1_inf_q  <= special_valid_i && special_inf_i;
        p1_zero_q <= special_valid_i && special_haszero_i;
        p1_nv_q   <= special_inv_i || snan_a || snan_b;
        p1_sign_q <= prod_sign_i;
        p1_rm_q   <= rm_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage P2: normalise and pack
  // ---------------------------------------------------------------------------
  logic [2:0]           lead_pos;
  logic [OEXPWIDTH-1:0] exp_biased;
  logic [PW-2:0]        frac_bits;
  logic [OW-1:0]        data_d;
  logic [TC_FFLAG_W-1:0] fflags_d;

  fp_lzc8 u_lzc (
    .in_i  (p1_prod_q),
    .pos_o (lead_pos)
  );

  always_comb begin
    // Product of two (PRECISION)-fraction significands has 2*PRECISION fraction bits.
    exp_biased = OEXPWIDTH'(p1_esum_q + ESW'(lead_pos) + ESW'(OBIAS) - ESW'(2 * PRECISION));
    // Shift the leading one out of the top so the remaining bits are left-aligned.
    frac_bits  = (PW-1)'(p1_prod_q << (3'(PW - 1) - lead_pos));

    if (p1_nan_q) begin
      data_d = OW'(TC_FP22_QNAN);
    end else if (p1_inf_q) begin
      data_d = {p1_sign_q, {OEXPWIDTH{1'b1}}, {OPRECISION{1'b0}}};
    end else if (p1_zero_q) begin
      data_d = {p1_sign_q, {(OW-1){1'b0}}};
    end else begin
      data_d = {p1_sign_q, exp_biased, frac_bits, {(OPRECISION-PW+1){1'b0}}};
    end

    fflags_d              = '0;
    fflags_d[TC_FFLAG_NV] = p1_nv_q;
    fflags_d[TC_FFLAG_DZ] = 1'b0;
    fflags_d[TC_FFLAG_OF] = 1'b0;
    fflags_d[TC_FFLAG_UF] = 1'b0;
    fflags_d[TC_FFLAG_NX] = 1'b0;
  end

  logic                  p2_valid_q;
  logic [OW-1:0]         p2_data_q;
  logic [TC_FFLAG_W-1:0] p2_fflags_q;
  logic [2:0]            p2_rm_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p2_valid_q  <= 1'b0;
      p2_data_q   <= '0;
      p2_fflags_q <= '0;
      p2_rm_q     <= '0;
    end else if (p2_load) begin
      p2_valid_q <= p1_valid_q;
      // Payload only moves with a real beat so the outputs never show bubbles.
      if (p1_valid_q) begin
        p2_data_q   <= data_d;
        p2_fflags_q <= fflags_d;
        p2_rm_q     <= p1_rm_q;
      end
    end
  end

  assign m_valid_o  = p2_valid_q;
  assign m_data_o   = p2_data_q;
  assign m_fflags_o = p2_fflags_q;
  assign m_rm_o     = p2_rm_q;

endmodule

// File: tb/tb_fmul_s2.sv
// Self-checking bench for fmul_s2: directed vectors, backpressure, reset
// mid-flight and a randomized scoreboard against a real-valued model.
module tb_fmul_s2;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready;
  logic [8:0]  a, b;
  logic        sp_valid, sp_nan, sp_inf, sp_inv, sp_zero, sign;
  logic [2:0]  rm;
  logic        m_valid, m_ready;
  logic [21:0] m_data;
  logic [4:0]  m_fflags;
  logic [2:0]  m_rm;

  int errors = 0;
  int checks = 0;

  logic [29:0] sb_q[$];

  always #5 clk = ~clk;

  fmul_s2 dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .s_valid_i         (s_valid),
    .s_ready_o         (s_ready),
    .a_i               (a),
    .b_i               (b),
    .special_valid_i   (sp_valid),
    .special_nan_i     (sp_nan),
    .special_inf_i     (sp_inf),
    .special_inv_i     (sp_inv),
    .special_haszero_i (sp_zero),
    .prod_sign_i       (sign),
    .rm_i              (rm),
    .m_valid_o         (m_valid),
    .m_ready_i         (m_ready),
    .m_data_o          (m_data),
    .m_fflags_o        (m_fflags),
    .m_rm_o            (m_rm)
  );

  // ---------------------------------------------------------------- model
  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp9_mag(input logic [8:0] x);
    int e = int'(x[7:3]);
    int f = int'(x[2:0]);
    if (e == 0) return (f / 8.0) * pow2(-14);
    return (1.0 + f / 8.0) * pow2(e - 15);
  endfunction

  function automatic logic is_snan(input logic [8:0] x);
    return (x[7:3] == 5'h1F) && !x[2] && (x[1:0] != 2'b00);
  endfunction

  function automatic logic [21:0] model_data(input logic [8:0] x, input logic [8:0] y,
                                             input logic nan, input logic inf,
                                             input logic zero);
    logic s = x[8] ^ y[8];
    real  v;
    int   e;
    int   fr;
    int   ex;
    if (nan) return 22'h1FF000;
    if (inf) return {s, 8'hFF, 13'h0};
    if (zero) return {s, 21'h0};
    v = fp9_mag(x) * fp9_mag(y);
    e = 0;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0) begin v = v * 2.0; e--; end
    fr = int'((v - 1.0) * 8192.0);
    ex = e + 127;
    return {s, ex[7:0], fr[12:0]};
  endfunction

  // Drive one beat, deriving first-stage classification from the operands.
  task automatic drive_beat(input logic [8:0] x, input logic [8:0] y, input logic [2:0] r);
    logic ia, ib, na, nb, za, zb;
    ia = (x[7:3] == 5'h1F) && (x[2:0] == 3'b0);
    ib = (y[7:3] == 5'h1F) && (y[2:0] == 3'b0);
    na = (x[7:3] == 5'h1F) && (x[2:0] != 3'b0);
    nb = (y[7:3] == 5'h1F) && (y[2:0] != 3'b0);
    za = (x[7:0] == 8'h0);
    zb = (y[7:0] == 8'h0);
    a        = x;
    b        = y;
    rm       = r;
    sign     = x[8] ^ y[8];
    sp_nan   = na || nb || (ia && zb) || (ib && za);
    sp_inf   = (ia || ib) && !sp_nan;
    sp_zero  = za || zb;
    sp_inv   = (ia && zb) || (ib && za);
    sp_valid = sp_nan || sp_inf || sp_zero;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    drive_beat(9'h078, 9'h078, 3'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    checks++;
    if ({m_data, m_fflags, m_rm} !== 30'h0)
      begin errors++; $display("FAIL reset_outputs got %h want 0", {m_data, m_fflags, m_rm}); end
  endtask

  task automatic test_directed();
    logic [8:0]  va[10] = '{9'h078, 9'h07C, 9'h0F7, 9'h001, 9'h0F8,
                            9'h0F9, 9'h1F8, 9'h100, 9'h0FC, 9'h180};
    logic [8:0]  vb[10] = '{9'h078, 9'h07C, 9'h0F7, 9'h001, 9'h000,
                            9'h078, 9'h078, 9'h07C, 9'h078, 9'h078};
    logic [21:0] vd[10] = '{22'h0FE000, 22'h100400, 22'h13D840, 22'h0BA000, 22'h1FF000,
                            22'h1FF000, 22'h3FE000, 22'h200000, 22'h1FF000, 22'h300000};
    logic [4:0]  vf[10] = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h10,
                            5'h10, 5'h00, 5'h00, 5'h00, 5'h00};
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      drive_beat(va[i], vb[i], 3'(i));
      s_valid = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid got %b want 0", i, m_valid); end
      @(posedge clk); #1;
      checks++;
      if (m_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_valid got %b want 1", i, m_valid); end
      checks++;
      if (m_data !== vd[i]) begin errors++; $display("FAIL dir%0d_data got %h want %h", i, m_data, vd[i]); end
      checks++;
      if (m_fflags !== vf[i]) begin errors++; $display("FAIL dir%0d_flags got %b want %b", i, m_fflags, vf[i]); end
      checks++;
      if (m_rm !== 3'(i)) begin errors++; $display("FAIL dir%0d_rm got %0d want %0d", i, m_rm, i); end
    end
  endtask

  task automatic test_backpressure();
    logic [8:0]  ops[3]  = '{9'h078, 9'h07C, 9'h001};
    logic [21:0] exps[3] = '{22'h0FE000, 22'h100400, 22'h0BA000};
    logic        rdy_exp[3] = '{1'b1, 1'b1, 1'b0};
    @(posedge clk); #1;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_beat(ops[i], ops[i], 3'(i + 1));
      s_valid = 1'b1;
      #1;
      checks++;
      if (s_ready !== rdy_exp[i])
        begin errors++; $display("FAIL bp_ready%0d got %b want %b", i, s_ready, rdy_exp[i]); end
      if (i < 2) begin @(posedge clk); #1; end
    end
    // Hold a full stall cycle: output must not move.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #2;
      checks++;
      if ({m_valid, s_ready, m_data, m_rm} !== {1'b1, 1'b0, exps[0], 3'd1})
        begin errors++; $display("FAIL bp_hold%0d got %b %b %h %0d want 1 0 %h 1",
                                 k, m_valid, s_ready, m_data, m_rm, exps[0]); end
    end
    m_ready = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", s_ready); end
    @(posedge clk); #1;
    s_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      checks++;
      if ({m_valid, m_data, m_rm} !== {1'b1, exps[i], 3'(i + 1)})
        begin errors++; $display("FAIL bp_drain%0d got %b %h %0d want 1 %h %0d",
                                 i, m_valid, m_data, m_rm, exps[i], i + 1); end
      @(posedge clk); #1;
    end
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", m_valid); end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    drive_beat(9'h078, 9'h078, 3'd5);
    s_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    drive_beat(9'h07C, 9'h07C, 3'd6);
    @(posedge clk); #1;
    rst = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    #1;
    checks++;
    if ({m_valid, s_ready, m_data} !== {1'b0, 1'b1, 22'h0})
      begin errors++; $display("FAIL rstmid_state got %b %b %h want 0 1 0", m_valid, s_ready, m_data); end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ghost%0d got %b want 0", k, m_valid); end
    end
  endtask

  task automatic test_random();
    int          sent = 0;
    int          cycles = 0;
    logic [8:0]  x, y;
    logic [29:0] exp_w, got_w;
    logic [4:0]  fl;
    while ((sent < 10000 || sb_q.size() > 0) && cycles < 80000) begin
      x = 9'($urandom_range(0, 511));
      y = 9'($urandom_range(0, 511));
      case ($urandom_range(0, 7))
        0: x[7:3] = 5'h00;
        1: x[7:3] = 5'h1F;
        2: y[7:3] = 5'h00;
        3: y[7:3] = 5'h1F;
        default: ;
      endcase
      drive_beat(x, y, 3'($urandom_range(0, 7)));
      s_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (m_valid && m_ready) begin
        got_w = {m_data, m_fflags, m_rm};
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL rnd_unexpected got %h want no beat", got_w);
        end else begin
          exp_w = sb_q.pop_front();
          if (got_w !== exp_w) begin
            errors++; $display("FAIL rnd_beat got %h want %h", got_w, exp_w);
          end
        end
      end
      if (s_valid && s_ready) begin
        fl = {sp_inv || is_snan(a) || is_snan(b), 4'b0};
        sb_q.push_back({model_data(a, b, sp_nan, sp_inf, sp_zero), fl, rm});
        sent++;
      end
      @(posedge clk); #1;
      cycles++;
    end
    s_valid = 1'b0;
    checks++;
    if (sb_q.size() != 0 || sent != 10000)
      begin errors++; $display("FAIL rnd_drain got sent=%0d pending=%0d want 10000 0", sent, sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
